// File: rtl/control_sequencer.sv
// control_sequencer: microcoded control unit for the 8-bit bus computer.
// Decodes ir opcode plus carry/zero flags, walks a 5-step T-state counter on
// the falling clock edge and drives every datapath control line.
// Optional build macro: EARLY_STEP_RESET_EN (return to T0 after the last
// active step of each instruction instead of always running T0..T4).
module control_sequencer #(
  parameter int unsigned N = 8,
  parameter int unsigned A = 4
) (
  input  logic         clk_i,
  input  logic         clr_ni,
  input  logic         prog_i,
  input  logic [N-1:0] ir_i,
  input  logic         cf_i,
  input  logic         zf_i,
  output logic         hlt_o,
  output logic         mi_o,
  output logic         ri_o,
  output logic         ro_no,
  output logic         ii_o,
  output logic         io_o,
  output logic         ai_o,
  output logic         ao_o,
  output logic         eo_o,
  output logic         su_o,
  output logic         fi_o,
  output logic         bi_o,
  output logic         oi_o,
  output logic         ce_o,
  output logic         co_o,
  output logic         j_o,
  output logic [2:0]   step_o,
  output logic         halted_o
);

  typedef enum logic [2:0] {StT0, StT1, StT2, StT3, StT4} step_e;

  localparam logic [3:0] OpNop = 4'h0;
  localparam logic [3:0] OpLda = 4'h1;
  localparam logic [3:0] OpAdd = 4'h2;
  localparam logic [3:0] OpSub = 4'h3;
  localparam logic [3:0] OpSta = 4'h4;
  localparam logic [3:0] OpLdi = 4'h5;
  localparam logic [3:0] OpJmp = 4'h6;
  localparam logic [3:0] OpJc  = 4'h7;
  localparam logic [3:0] OpJz  = 4'h8;
  localparam logic [3:0] OpOut = 4'hE;
  localparam logic [3:0] OpHlt = 4'hF;

  step_e      step_q, step_d, last_step;
  logic       halted_q, halted_d;
  logic [3:0] opcode;

  assign opcode = ir_i[N-1:N-4];

  // Operand field never influences control; keep it visibly unused.
  logic unused_operand;
  assign unused_operand = ^ir_i[A-1:0];

  // Final active step of the current instruction.
`ifdef EARLY_STEP_RESET_EN
  always_comb begin
    last_step = StT1;
    case (opcode)
      OpLdi, OpJmp, OpJc, OpJz, OpOut, OpHlt: last_step = StT2;
      OpLda, OpSta:                           last_step = StT3;
      OpAdd, OpSub:                           last_step = StT4;
      default:                                last_step = StT1;
    endcase
  end
`else
  always_comb begin
    last_step = StT4;
  end
`endif

  // Step counter and halt flag advance on the falling edge.
  always_ff @(negedge clk_i or negedge clr_ni) begin
    if (!clr_ni) begin
      step_q   <= StT0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  // Next-state: halt beats prog; HLT freezes the counter at T2.
  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    if (halted_q) begin
      step_d = step_q;
    end else if (prog_i) begin
      step_d = StT0;
    end else if (step_q == StT2 && opcode == OpHlt) begin
      halted_d = 1'b1;
      step_d   = StT2;
    end else if (step_q == last_step || step_q == StT4) begin
      step_d = StT0;
    end else begin
      step_d = step_e'(3'(step_q + 3'd1));
    end
  end

  // Control decode; reset, halt and programming mode override the microcode.
  always_comb begin
    hlt_o = 1'b0; mi_o = 1'b0; ri_o = 1'b0; ro_no = 1'b1; ii_o = 1'b0;
    io_o  = 1'b0; ai_o = 1'b0; ao_o = 1'b0; eo_o  = 1'b0; su_o = 1'b0;
    fi_o  = 1'b0; bi_o = 1'b0; oi_o = 1'b0; ce_o  = 1'b0; co_o = 1'b0;
    j_o   = 1'b0;
    if (!clr_ni) begin
      hlt_o = 1'b0;
    end else if (halted_q) begin
      hlt_o = 1'b1;
    end else if (!prog_i) begin
      case (step_q)
        StT0: begin co_o = 1'b1; mi_o = 1'b1; end
        StT1: begin ro_no = 1'b0; ii_o = 1'b1; ce_o = 1'b1; end
        StT2: begin
          case (opcode)
            OpLda, OpAdd, OpSub, OpSta: begin io_o = 1'b1; mi_o = 1'b1; end
            OpLdi: begin io_o = 1'b1; ai_o = 1'b1; end
            OpJmp: begin io_o = 1'b1; j_o = 1'b1; end
            OpJc:  begin io_o = 1'b1; j_o = cf_i; end
            OpJz:  begin io_o = 1'b1; j_o = zf_i; end
            OpOut: begin ao_o = 1'b1; oi_o = 1'b1; end
            OpHlt: hlt_o = 1'b1;
            default: hlt_o = 1'b0;
          endcase
        end
        StT3: begin
          case (opcode)
            OpLda:        begin ro_no = 1'b0; ai_o = 1'b1; end
            OpAdd, OpSub: begin ro_no = 1'b0; bi_o = 1'b1; end
            OpSta:        begin ao_o = 1'b1; ri_o = 1'b1; end
            default:      ro_no = 1'b1;
          endcase
        end
        StT4: begin
          if (opcode == OpAdd || opcode == OpSub) begin
            eo_o = 1'b1; ai_o = 1'b1; fi_o = 1'b1;
            su_o = (opcode == OpSub);
          end
        end
        default: co_o = 1'b0;
      endcase
    end
  end

  assign step_o   = step_q;
  assign halted_o = halted_q;

  logic unused_opnop;
  assign unused_opnop = (OpNop == 4'h0);

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer (default build, early reset off).
module tb_control_sequencer;

  logic clk, clr_n, prog, cf, zf;
  logic [7:0] ir;
  logic hlt, mi, ri, ro_n, ii, io, ai, ao, eo, su, fi, bi, oi, ce, co, j;
  logic [2:0] step;
  logic halted;

  int checks = 0;
  int failures = 0;

  // Asserted-line masks; RO means ro_ driven low.
  localparam logic [15:0] HLT = 16'h8000, MI = 16'h4000, RI = 16'h2000, RO = 16'h1000;
  localparam logic [15:0] II  = 16'h0800, IO = 16'h0400, AI = 16'h0200, AO = 16'h0100;
  localparam logic [15:0] EO  = 16'h0080, SU = 16'h0040, FI = 16'h0020, BI = 16'h0010;
  localparam logic [15:0] OI  = 16'h0008, CE = 16'h0004, CO = 16'h0002, J  = 16'h0001;
  localparam logic [15:0] NONE = 16'h0000;

  control_sequencer dut (
    .clk_i(clk), .clr_ni(clr_n), .prog_i(prog), .ir_i(ir), .cf_i(cf), .zf_i(zf),
    .hlt_o(hlt), .mi_o(mi), .ri_o(ri), .ro_no(ro_n), .ii_o(ii), .io_o(io), .ai_o(ai),
    .ao_o(ao), .eo_o(eo), .su_o(su), .fi_o(fi), .bi_o(bi), .oi_o(oi), .ce_o(ce),
    .co_o(co), .j_o(j), .step_o(step), .halted_o(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  ir;
    logic        cf;
    logic        zf;
    logic        adv;
    logic [2:0]  st;
    logic [15:0] ctrl;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [7:0] i, input logic c, input logic z, input logic a,
                     input logic [2:0] s, input logic [15:0] w);
    vec_t v;
    v.ir = i; v.cf = c; v.zf = z; v.adv = a; v.st = s; v.ctrl = w;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [2:0] es, input logic eh,
                     input logic [15:0] ew);
    logic [15:0] w;
    w = {hlt, mi, ri, ~ro_n, ii, io, ai, ao, eo, su, fi, bi, oi, ce, co, j};
    checks++;
    if (step !== es || halted !== eh || w !== ew) begin
      failures++;
      $display("FAIL %s: got step=%0d halted=%0b ctrl=%h ro_=%b, want step=%0d halted=%0b ctrl=%h",
               name, step, halted, w, ro_n, es, eh, ew);
    end
  endtask

  // Advance one T-state and sample away from the posedge.
  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 clr_n = 1'b0;
    #2 clr_n = 1'b1;
    #1;
  endtask

  initial begin
    clr_n = 1'b0; prog = 1'b0; ir = 8'h00; cf = 1'b0; zf = 1'b0;
    #1;
    chk("reset_idle", 3'd0, 1'b0, NONE);

    // Table: {ir, cf, zf, advance-one-step, expected step, expected lines}.
    add(8'h1E, 0, 0, 0, 3'd0, CO | MI);
    add(8'h1E, 0, 0, 1, 3'd1, RO | II | CE);
    add(8'h1E, 0, 0, 1, 3'd2, IO | MI);
    add(8'h1E, 0, 0, 1, 3'd3, RO | AI);
    add(8'h1E, 0, 0, 1, 3'd4, NONE);
    add(8'h3F, 0, 0, 1, 3'd0, CO | MI);
    add(8'h3F, 0, 0, 1, 3'd1, RO | II | CE);
    add(8'h3F, 0, 0, 1, 3'd2, IO | MI);
    add(8'h3F, 0, 0, 1, 3'd3, RO | BI);
    add(8'h3F, 0, 0, 1, 3'd4, EO | AI | SU | FI);
    add(8'h2A, 0, 0, 0, 3'd4, EO | AI | FI);
    add(8'h74, 1, 0, 1, 3'd0, CO | MI);
    add(8'h74, 1, 0, 1, 3'd1, RO | II | CE);
    add(8'h74, 1, 0, 1, 3'd2, IO | J);
    add(8'h74, 0, 0, 0, 3'd2, IO);
    add(8'h84, 0, 1, 0, 3'd2, IO | J);
    add(8'h84, 0, 0, 0, 3'd2, IO);
    add(8'h84, 1, 0, 0, 3'd2, IO);
    add(8'h52, 0, 0, 0, 3'd2, IO | AI);
    add(8'h6C, 0, 0, 0, 3'd2, IO | J);
    add(8'hE0, 0, 0, 0, 3'd2, AO | OI);
    add(8'h43, 0, 0, 1, 3'd3, AO | RI);
    add(8'hB7, 0, 0, 0, 3'd3, NONE);
    add(8'h0F, 0, 0, 1, 3'd4, NONE);
    add(8'h0F, 0, 0, 1, 3'd0, CO | MI);
    add(8'h0F, 0, 0, 1, 3'd1, RO | II | CE);
    add(8'h0F, 0, 0, 1, 3'd2, NONE);
    add(8'h17, 0, 0, 0, 3'd2, IO | MI);

    do_reset();
    foreach (vecs[i]) begin
      ir = vecs[i].ir; cf = vecs[i].cf; zf = vecs[i].zf;
      if (vecs[i].adv) tick(); else #1;
      chk($sformatf("row%0d", i), vecs[i].st, 1'b0, vecs[i].ctrl);
    end

    // Reset asserted mid-T3 of LDA.
    ir = 8'h1E; cf = 1'b0; zf = 1'b0;
    do_reset();
    tick(); tick(); tick();
    chk("lda_t3", 3'd3, 1'b0, RO | AI);
    clr_n = 1'b0;
    #1 chk("clr_async", 3'd0, 1'b0, NONE);
    #1 clr_n = 1'b1;
    #1 chk("clr_release_t0", 3'd0, 1'b0, CO | MI);
    tick();
    chk("clr_then_t1", 3'd1, 1'b0, RO | II | CE);

    // HLT: freeze at T2, ignore prog, clear with clr_.
    ir = 8'hF0;
    do_reset();
    tick(); tick();
    chk("hlt_t2", 3'd2, 1'b0, HLT);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("halted%0d", k), 3'd2, 1'b1, HLT);
    end
    prog = 1'b1;
    tick(); tick();
    chk("halted_prog", 3'd2, 1'b1, HLT);
    prog = 1'b0;
    tick();
    chk("halted_unprog", 3'd2, 1'b1, HLT);
    clr_n = 1'b0;
    #1 chk("halt_cleared", 3'd0, 1'b0, NONE);
    #1 clr_n = 1'b1;
    #1 chk("halt_restart", 3'd0, 1'b0, CO | MI);

    // prog raised during T2 of ADD.
    ir = 8'h25;
    do_reset();
    tick(); tick();
    chk("add_t2", 3'd2, 1'b0, IO | MI);
    prog = 1'b1;
    #1 chk("prog_idle_now", 3'd2, 1'b0, NONE);
    tick();
    chk("prog_step0", 3'd0, 1'b0, NONE);
    tick();
    chk("prog_hold", 3'd0, 1'b0, NONE);
    prog = 1'b0;
    #1 chk("prog_resume_t0", 3'd0, 1'b0, CO | MI);
    tick();
    chk("prog_resume_t1", 3'd1, 1'b0, RO | II | CE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

endmodule
